// File: rtl/l9_bram1_seq.sv
// Layer-9 BRAM address sequencer: LOAD -> CONV -> WB -> [READ] -> DONE sweep over L/x/y/k/z.
// Build macro L9_SEQ_READBACK_EN enables the READ phase; without it WB goes straight to DONE.
module l9_bram1_seq #(
  parameter int unsigned X_LAST = 7,
  parameter int unsigned Y_LAST = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stall,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic [1:0] L,
  output logic [1:0] k,
  output logic [2:0] u,
  output logic [2:0] z,
  output logic [3:0] x_Reg5,
  output logic [3:0] y_Reg5,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  localparam int unsigned DLY = 5;

  localparam logic [2:0] U_LOAD = 3'd0;
  localparam logic [2:0] U_CONV = 3'd3;
  localparam logic [2:0] U_WB   = 3'd4;
  localparam logic [2:0] U_READ = 3'd5;
  localparam logic [2:0] U_IDLE = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CONV,
    S_WB,
    S_READ,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [3:0]  r_x, r_y;
  logic [1:0]  r_l, r_k;
  logic [2:0]  r_z, r_u;
  logic        r_busy, r_done, r_act;
  logic [3:0]  r_dx [DLY];
  logic [3:0]  r_dy [DLY];

  state_t      w_state_nxt;
  logic [3:0]  w_x_nxt, w_y_nxt;
  logic [1:0]  w_l_nxt, w_k_nxt;
  logic [2:0]  w_z_nxt, w_u_nxt;
  logic        w_busy_nxt, w_done_nxt, w_act_nxt;

  logic        w_y_last, w_x_last, w_l_last;
  logic [3:0]  w_y_step, w_x_step;
  logic [1:0]  w_l_step;
  logic        w_pos_end, w_sweep_end;

  // Shared y-innermost sweep: y, then x, then L, each wrapping exactly at its last value
  assign w_y_last    = (r_y == 4'(Y_LAST));
  assign w_x_last    = (r_x == 4'(X_LAST));
  assign w_l_last    = (r_l == 2'd3);
  assign w_y_step    = w_y_last ? 4'd0 : r_y + 4'd1;
  assign w_x_step    = w_y_last ? (w_x_last ? 4'd0 : r_x + 4'd1) : r_x;
  assign w_l_step    = (w_y_last && w_x_last) ? (w_l_last ? 2'd0 : r_l + 2'd1) : r_l;
  assign w_pos_end   = w_y_last && w_x_last;
  assign w_sweep_end = w_pos_end && w_l_last;

  // Next-state and next-counter logic; the register stage applies it only on non-stalled edges
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_l_nxt     = r_l;
    w_k_nxt     = r_k;
    w_z_nxt     = r_z;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
          w_x_nxt     = 4'd0;
          w_y_nxt     = 4'd0;
          w_l_nxt     = 2'd0;
          w_k_nxt     = 2'd0;
          w_z_nxt     = 3'd0;
        end
      end
      S_LOAD, S_READ: begin
        w_y_nxt = w_y_step;
        w_x_nxt = w_x_step;
        w_l_nxt = w_l_step;
        if (w_sweep_end) begin
          if (r_state == S_LOAD) begin
            w_state_nxt = S_CONV;
            w_k_nxt     = 2'd1;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_CONV: begin
        if (r_k == 2'd3) begin
          w_k_nxt = 2'd1;
          w_y_nxt = w_y_step;
          w_x_nxt = w_x_step;
          w_l_nxt = w_l_step;
          if (w_sweep_end) begin
            w_state_nxt = S_WB;
            w_k_nxt     = 2'd0;
            w_z_nxt     = 3'd1;
          end
        end else begin
          w_k_nxt = r_k + 2'd1;
        end
      end
      S_WB: begin
        // z walks 1,2,3,0 at each position; the position advances after z=0
        w_z_nxt = (r_z == 3'd3) ? 3'd0 : r_z + 3'd1;
        if (r_z == 3'd0) begin
          w_y_nxt = w_y_step;
          w_x_nxt = w_x_step;
          if (w_pos_end) begin
            w_z_nxt = 3'd0;
`ifdef L9_SEQ_READBACK_EN
            w_state_nxt = S_READ;
`else
            w_state_nxt = S_DONE;
`endif
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_x_nxt     = 4'd0;
        w_y_nxt     = 4'd0;
        w_l_nxt     = 2'd0;
        w_k_nxt     = 2'd0;
        w_z_nxt     = 3'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Phase code and status flags decoded from the next state so they register with it
  always_comb begin
    w_u_nxt    = U_IDLE;
    w_busy_nxt = 1'b1;
    w_done_nxt = 1'b0;
    w_act_nxt  = 1'b0;
    unique case (w_state_nxt)
      S_IDLE: w_busy_nxt = 1'b0;
      S_LOAD: begin w_u_nxt = U_LOAD; w_act_nxt = 1'b1; end
      S_CONV: begin w_u_nxt = U_CONV; w_act_nxt = 1'b1; end
      S_WB:   begin w_u_nxt = U_WB;   w_act_nxt = 1'b1; end
      S_READ: begin w_u_nxt = U_READ; w_act_nxt = 1'b1; end
      S_DONE: w_done_nxt = 1'b1;
      default: w_busy_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= 4'd0;
      r_y     <= 4'd0;
      r_l     <= 2'd0;
      r_k     <= 2'd0;
      r_z     <= 3'd0;
      r_u     <= U_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_act   <= 1'b0;
    end else if (!stall) begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_l     <= w_l_nxt;
      r_k     <= w_k_nxt;
      r_z     <= w_z_nxt;
      r_u     <= w_u_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_act   <= w_act_nxt;
    end
  end

  // Free-running coordinate delay line, frozen only by stall
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DLY); i++) begin
        r_dx[i] <= 4'd0;
        r_dy[i] <= 4'd0;
      end
    end else if (!stall) begin
      r_dx[0] <= r_x;
      r_dy[0] <= r_y;
      for (int i = 1; i < int'(DLY); i++) begin
        r_dx[i] <= r_dx[i-1];
        r_dy[i] <= r_dy[i-1];
      end
    end
  end

  assign x      = r_x;
  assign y      = r_y;
  assign L      = r_l;
  assign k      = r_k;
  assign z      = r_z;
  assign u      = r_u;
  assign busy   = r_busy;
  assign done   = r_done;
  assign x_Reg5 = r_dx[DLY-1];
  assign y_Reg5 = r_dy[DLY-1];
  assign valid  = r_act && !stall;

endmodule
